register_uart_reporter: RTL and testbench

//  Downstream consumer of the CPU's debug outputs (pc, register1Value). When register1Value changes,

---
 rtl/puc_debug_pkg.sv | 26 ++
 rtl/register_uart_reporter_if.sv | 19 +
 rtl/uart_tx_byte.sv | 97 +++++++++
 rtl/register_uart_reporter.sv | 148 ++++++++++++++
 tb/tb_register_uart_reporter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/puc_debug_pkg.sv
// puc_debug_pkg: shared definitions for the CPU debug UART reporter.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - ASCII framing characters used in a report line
//   - hex_to_ascii: 4-bit nibble to uppercase ASCII hex digit
package puc_debug_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StStart = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StStop  = 3'd4;
    localparam logic [2:0] StNext  = 3'd5;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F'
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/register_uart_reporter_if.sv
// register_uart_reporter_if: bundle between the CPU debug outputs and the reporter.
//   pc, register1Value : watched CPU state (driven by the CPU side)
//   txd                : UART serial out, idle high
//   busy               : a report line is in flight
//   overrunCount       : saturating count of changes coalesced while busy
// Modports: master = CPU/board side, slave = reporter.
interface register_uart_reporter_if #(
    parameter int unsigned PC_WIDTH       = 8,
    parameter int unsigned REGISTER_WIDTH = 8
);
    logic [PC_WIDTH-1:0]       pc;
    logic [REGISTER_WIDTH-1:0] register1Value;
    logic                      txd;
    logic                      busy;
    logic [7:0]                overrunCount;

    modport master (output pc, output register1Value, input txd, input busy, input overrunCount);
    modport slave  (input pc, input register1Value, output txd, output busy, output overrunCount);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: single-byte 8N1 serializer, LSB first.
//   clk_i, rst_i : clock and synchronous active-high reset
//   valid_i      : byte offered; accepted when valid_i && ready_o
//   data_i       : byte to send
//   ready_o      : high only while idle
//   txd_o        : registered serial output, idle high
// Each bit (start, 8 data, stop) is held exactly CLKS_PER_BIT cycles.
module uart_tx_byte import puc_debug_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txd_o
);
    localparam int unsigned       CntW   = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0]   CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            last_tick;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        last_tick = (cnt_q == CntMax);
        if (state_q != StIdle) begin
            cnt_d = last_tick ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (valid_i) begin
                    shift_d = data_i;
                    txd_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (last_tick) begin
                    txd_d   = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (last_tick) begin
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (last_tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign ready_o = (state_q == StIdle);
    assign txd_o   = txd_q;

endmodule

// File: rtl/register_uart_reporter.sv
// register_uart_reporter: when the watched CPU register changes, sends one ASCII line
// "<pc hex>:<reg hex>\r\n" out an 8N1 UART pin.
//   clock   : single clock, all state on the rising edge
//   isReset : synchronous active-high reset
//   dbg     : slave side of register_uart_reporter_if (pc, register1Value in;
//             txd, busy, overrunCount out)
// The top owns the character sequencer, change detection and the overrun counter;
// uart_tx_byte serializes each character.
module register_uart_reporter import puc_debug_pkg::*; #(
    parameter int unsigned PC_WIDTH       = 8,
    parameter int unsigned REGISTER_WIDTH = 8,
    parameter int unsigned CLOCK_HZ       = 50_000_000,
    parameter int unsigned BAUD           = 115200
) (
    input logic                     clock,
    input logic                     isReset,
    register_uart_reporter_if.slave dbg
);
    localparam int unsigned ClksPerBit = CLOCK_HZ / BAUD;
    localparam int unsigned PcDigits   = (PC_WIDTH + 3) / 4;
    localparam int unsigned RegDigits  = (REGISTER_WIDTH + 3) / 4;
    localparam int unsigned LineLen    = PcDigits + RegDigits + 3;
    localparam int unsigned PcPadW     = PcDigits * 4;
    localparam int unsigned RegPadW    = RegDigits * 4;
    localparam logic [7:0]  LastIdx    = 8'(LineLen - 1);

    logic [2:0]                state_q, state_d;
    logic [7:0]                char_idx_q, char_idx_d;
    logic [PcPadW-1:0]         pc_snap_q, pc_snap_d;
    logic [RegPadW-1:0]        reg_snap_q, reg_snap_d;
    logic [REGISTER_WIDTH-1:0] last_q, last_d;
    logic [REGISTER_WIDTH-1:0] prev_q;
    logic                      force_q, force_d;
    logic                      busy_q, busy_d;
    logic [7:0]                overrun_q, overrun_d;

    logic                      tx_valid, tx_ready;
    logic [7:0]                char_byte;
    logic [PcPadW-1:0]         pc_sh;
    logic [RegPadW-1:0]        reg_sh;
    int unsigned               pos;

    // Character at char_idx_q, taken from the frozen snapshot.
    always_comb begin
        pos       = 32'(char_idx_q);
        pc_sh     = pc_snap_q >> ((PcDigits - 1 - pos) * 4);
        reg_sh    = reg_snap_q >> ((PcDigits + RegDigits - pos) * 4);
        char_byte = ASCII_LF;
        if (pos < PcDigits) begin
            char_byte = hex_to_ascii(pc_sh[3:0]);
        end else if (pos == PcDigits) begin
            char_byte = ASCII_COLON;
        end else if (pos < PcDigits + 1 + RegDigits) begin
            char_byte = hex_to_ascii(reg_sh[3:0]);
        end else if (pos == LineLen - 2) begin
            char_byte = ASCII_CR;
        end
    end

    always_comb begin
        state_d    = state_q;
        char_idx_d = char_idx_q;
        pc_snap_d  = pc_snap_q;
        reg_snap_d = reg_snap_q;
        last_d     = last_q;
        force_d    = force_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        tx_valid   = 1'b0;

        if (busy_q && (dbg.register1Value != prev_q) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end

        case (state_q)
            StIdle: begin
                if (force_q || (dbg.register1Value != last_q)) begin
                    pc_snap_d  = PcPadW'(dbg.pc);
                    reg_snap_d = RegPadW'(dbg.register1Value);
                    last_d     = dbg.register1Value;
                    force_d    = 1'b0;
                    busy_d     = 1'b1;
                    char_idx_d = 8'd0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d = StData;
                end
            end
            StData: begin
                // The first cycle the serializer is ready again is the inter-character
                // NEXT cycle: it keeps each character at exactly 10 bits + 2 cycles.
                if (tx_ready) begin
                    if (char_idx_q == LastIdx) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        char_idx_d = char_idx_q + 8'd1;
                        state_d    = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            state_q    <= StIdle;
            char_idx_q <= 8'd0;
            pc_snap_q  <= '0;
            reg_snap_q <= '0;
            last_q     <= '0;
            prev_q     <= '0;
            force_q    <= 1'b1;
            busy_q     <= 1'b0;
            overrun_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            char_idx_q <= char_idx_d;
            pc_snap_q  <= pc_snap_d;
            reg_snap_q <= reg_snap_d;
            last_q     <= last_d;
            prev_q     <= dbg.register1Value;
            force_q    <= force_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(ClksPerBit)
    ) u_tx (
        .clk_i  (clock),
        .rst_i  (isReset),
        .valid_i(tx_valid),
        .data_i (char_byte),
        .ready_o(tx_ready),
        .txd_o  (dbg.txd)
    );

    assign dbg.busy         = busy_q;
    assign dbg.overrunCount = overrun_q;

endmodule

// File: tb/tb_register_uart_reporter.sv
// Bench for register_uart_reporter: two instances (8/8-bit and 10/6-bit) at 16 clocks per bit.
// Stimulus pushes expected line bytes into per-DUT queues; per-DUT UART monitors decode txd
// and pop/compare each received character.
module tb_register_uart_reporter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8;
    logic rstw;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] q8[$];
    logic [7:0] qw[$];

    register_uart_reporter_if #(.PC_WIDTH(8),  .REGISTER_WIDTH(8)) if8 ();
    register_uart_reporter_if #(.PC_WIDTH(10), .REGISTER_WIDTH(6)) ifw ();

    register_uart_reporter #(
        .PC_WIDTH(8), .REGISTER_WIDTH(8), .CLOCK_HZ(16), .BAUD(1)
    ) dut8 (
        .clock  (clk),
        .isReset(rst8),
        .dbg    (if8)
    );

    register_uart_reporter #(
        .PC_WIDTH(10), .REGISTER_WIDTH(6), .CLOCK_HZ(16), .BAUD(1)
    ) dutw (
        .clock  (clk),
        .isReset(rstw),
        .dbg    (ifw)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic txd_of(input int which);
        return (which == 0) ? if8.txd : ifw.txd;
    endfunction

    function automatic logic rst_of(input int which);
        return (which == 0) ? rst8 : rstw;
    endfunction

    function automatic logic busy_of(input int which);
        return (which == 0) ? if8.busy : ifw.busy;
    endfunction

    // Captures one frame starting at the negedge where the start bit was first seen.
    task automatic mon_frame(input int which, output bit aborted, output logic [7:0] data,
                             output bit start_ok, output bit stop_ok);
        logic s [0:152];
        aborted = 1'b0;
        data    = 8'h00;
        start_ok = 1'b0;
        stop_ok  = 1'b0;
        s[0] = txd_of(which);
        for (int off = 1; off <= 152; off++) begin
            @(negedge clk);
            if (rst_of(which)) begin
                aborted = 1'b1;
                return;
            end
            s[off] = txd_of(which);
        end
        start_ok = 1'b1;
        for (int i = 0; i < 16; i++) if (s[i] !== 1'b0) start_ok = 1'b0;
        for (int k = 0; k < 8; k++) data[k] = s[16 * (k + 1) + 8];
        stop_ok = 1'b1;
        for (int i = 144; i <= 152; i++) if (s[i] !== 1'b1) stop_ok = 1'b0;
    endtask

    task automatic run_monitor(input int which);
        logic       prev;
        bit         ab, so, sp, have;
        logic [7:0] b, exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_of(which) && prev === 1'b1 && txd_of(which) === 1'b0) begin
                mon_frame(which, ab, b, so, sp);
                if (!ab) begin
                    have = 1'b0;
                    exp  = 8'h00;
                    if (which == 0 && q8.size() > 0) begin
                        exp = q8.pop_front();
                        have = 1'b1;
                    end else if (which == 1 && qw.size() > 0) begin
                        exp = qw.pop_front();
                        have = 1'b1;
                    end
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_char dut%0d actual=%02h required=none", which, b);
                    end else begin
                        chk($sformatf("char_dut%0d", which), {24'h0, b}, {24'h0, exp});
                    end
                    chk($sformatf("start_bit16_dut%0d", which), {31'h0, so}, 32'd1);
                    chk($sformatf("stop_bit_dut%0d", which), {31'h0, sp}, 32'd1);
                end
                prev = 1'b1;
            end else begin
                prev = txd_of(which);
            end
        end
    endtask

    initial run_monitor(0);
    initial run_monitor(1);

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pushes the line text followed by CR LF.
    task automatic push_line(input int which, input string s);
        logic [7:0] ch;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (which == 0) q8.push_back(ch); else qw.push_back(ch);
        end
        if (which == 0) begin
            q8.push_back(8'h0D);
            q8.push_back(8'h0A);
        end else begin
            qw.push_back(8'h0D);
            qw.push_back(8'h0A);
        end
    endtask

    task automatic wait_drain(input int which, input string name);
        int n;
        n = 0;
        while ((((which == 0) ? q8.size() : qw.size()) != 0 || busy_of(which)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'h0, (n >= 20000)}, 32'd0);
    endtask

    initial begin
        int n;
        bit seen;

        rst8 = 1'b1;
        rstw = 1'b1;
        if8.pc = 8'h05;
        if8.register1Value = 8'h00;
        ifw.pc = 10'h000;
        ifw.register1Value = 6'h00;
        cycles(4);
        chk("reset_txd", {31'h0, if8.txd}, 32'd1);
        chk("reset_busy", {31'h0, if8.busy}, 32'd0);
        chk("reset_overrun", {24'h0, if8.overrunCount}, 32'd0);

        // Forced report after reset; start bit on the second edge.
        push_line(0, "05:00");
        rst8 = 1'b0;
        @(negedge clk);
        chk("t1_busy_on_trigger", {31'h0, if8.busy}, 32'd1);
        chk("t1_txd_load_high", {31'h0, if8.txd}, 32'd1);
        @(negedge clk);
        chk("t1_start_bit", {31'h0, if8.txd}, 32'd0);
        wait_drain(0, "t1_drain");
        chk("t1_overrun", {24'h0, if8.overrunCount}, 32'd0);

        // One line; changes 3A->11->22->3A while busy coalesce to nothing.
        if8.pc = 8'h07;
        if8.register1Value = 8'h3A;
        push_line(0, "07:3A");
        n = 0;
        @(negedge clk);
        while (if8.busy && n < 5000) begin
            n++;
            if (n == 100) if8.register1Value = 8'h11;
            if (n == 200) if8.register1Value = 8'h22;
            if (n == 300) if8.register1Value = 8'h3A;
            @(negedge clk);
        end
        chk("t2_busy_cycles", n, 32'd1134);
        cycles(200);
        chk("t3_no_report_on_return", {31'h0, if8.busy}, 32'd0);
        chk("t3_overrun3", {24'h0, if8.overrunCount}, 32'd3);

        // Change mid-line reported once after the line ends.
        if8.register1Value = 8'h12;
        push_line(0, "07:12");
        cycles(300);
        if8.pc = 8'h09;
        if8.register1Value = 8'h44;
        push_line(0, "09:44");
        wait_drain(0, "t3_drain");
        chk("t3_overrun4", {24'h0, if8.overrunCount}, 32'd4);

        // pc change alone never triggers.
        if8.pc = 8'h33;
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (if8.busy) seen = 1'b1;
        end
        chk("pc_only_no_report", {31'h0, seen}, 32'd0);

        // Reset during data bits of char 3 abandons the line.
        if8.register1Value = 8'h5C;
        push_line(0, "33:5C");
        cycles(3 * 162 + 40);
        rst8 = 1'b1;
        @(negedge clk);
        chk("t4_txd_after_reset", {31'h0, if8.txd}, 32'd1);
        chk("t4_busy_after_reset", {31'h0, if8.busy}, 32'd0);
        chk("t4_overrun_after_reset", {24'h0, if8.overrunCount}, 32'd0);
        cycles(3);
        q8.delete();
        push_line(0, "33:5C");
        rst8 = 1'b0;
        wait_drain(0, "t4_forced_drain");

        // Overrun saturation.
        if8.register1Value = 8'h01;
        push_line(0, "33:01");
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            if8.register1Value = (i % 2 == 0) ? 8'h02 : 8'h03;
            @(negedge clk);
        end
        chk("t5_overrun_sat", {24'h0, if8.overrunCount}, 32'd255);
        if8.register1Value = 8'h01;
        wait_drain(0, "t5_drain");
        cycles(50);
        chk("t5_overrun_no_wrap", {24'h0, if8.overrunCount}, 32'd255);
        chk("t5_no_extra_line", {31'h0, if8.busy}, 32'd0);

        // Narrow/odd widths: zero-padded upper digits.
        ifw.pc = 10'h3FF;
        ifw.register1Value = 6'h2A;
        push_line(1, "3FF:2A");
        rstw = 1'b0;
        wait_drain(1, "t6_drain_a");
        ifw.pc = 10'h001;
        ifw.register1Value = 6'h05;
        push_line(1, "001:05");
        wait_drain(1, "t6_drain_b");

        cycles(20);
        chk("final_q8_empty", q8.size(), 32'd0);
        chk("final_qw_empty", qw.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
